// File: rtl/data_memory_if.sv
// -----------------------------------------------------------------------------
// data_memory_if
// Request/response bundle between the execute stage (master) and the
// data memory / load-store unit (slave).
//   addr_i       : byte address (ALU result)
//   data_i       : store data (rs2)
//   read_en_i    : load request this cycle
//   write_en_i   : store request this cycle
//   funct3_i     : access size and sign
//   data_o       : extended load result, registered
//   data_vld_o   : data_o holds the previous cycle's load result
//   access_err_o : previous cycle's request was suppressed
// Signal suffixes are from the memory's point of view.
// -----------------------------------------------------------------------------
interface data_memory_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0] addr_i;
  logic [DWIDTH-1:0] data_i;
  logic              read_en_i;
  logic              write_en_i;
  logic [2:0]        funct3_i;
  logic [DWIDTH-1:0] data_o;
  logic              data_vld_o;
  logic              access_err_o;

  modport master (
    output addr_i, data_i, read_en_i, write_en_i, funct3_i,
    input  data_o, data_vld_o, access_err_o
  );

  modport slave (
    input  addr_i, data_i, read_en_i, write_en_i, funct3_i,
    output data_o, data_vld_o, access_err_o
  );
endinterface

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Byte-addressable little-endian data memory with load/store unit for the
// memory stage. Loads return a sized, sign/zero-extended result one cycle
// after the request; misaligned, out-of-range and unsupported-size requests
// are suppressed and flagged on access_err_o.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (outputs only; memory is not reset)
//   bus   : data_memory_if slave modport (request in, registered response out)
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int                AWIDTH      = 32,
  parameter int                DWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h0100_0000,
  parameter int                DEPTH_BYTES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  data_memory_if.slave    bus
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  logic [7:0]        r_mem [DEPTH_BYTES];
  logic [DWIDTH-1:0] r_data;
  logic              r_vld;
  logic              r_err;

  logic [AWIDTH-1:0] w_offset;
  logic [AWIDTH:0]   w_end;
  logic [2:0]        w_size;
  logic [IDX_W-1:0]  w_idx0, w_idx1, w_idx2, w_idx3;
  logic [7:0]        w_b0, w_b1, w_b2, w_b3;
  logic              w_ld_legal, w_st_legal, w_misalign, w_in_range;
  logic              w_err, w_load, w_store;
  logic [DWIDTH-1:0] w_ld_data;

  // Wraps modulo 2^AWIDTH, so addresses below BASE_ADDR become huge offsets
  // and fail the range check.
  assign w_offset = bus.addr_i - BASE_ADDR;

  always_comb begin
    w_size = 3'd0;
    case (bus.funct3_i[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      2'b10:   w_size = 3'd4;
      default: w_size = 3'd0;
    endcase
  end

  assign w_ld_legal = (bus.funct3_i == 3'b000) || (bus.funct3_i == 3'b001) ||
                      (bus.funct3_i == 3'b010) || (bus.funct3_i == 3'b100) ||
                      (bus.funct3_i == 3'b101);
  assign w_st_legal = (bus.funct3_i == 3'b000) || (bus.funct3_i == 3'b001) ||
                      (bus.funct3_i == 3'b010);

  assign w_misalign = ((bus.funct3_i[1:0] == 2'b01) && w_offset[0]) ||
                      ((bus.funct3_i[1:0] == 2'b10) && (w_offset[1:0] != 2'b00));

  // One extra bit so offset + size cannot overflow the comparison.
  assign w_end      = {1'b0, w_offset} + (AWIDTH+1)'(w_size);
  assign w_in_range = (w_end <= (AWIDTH+1)'(DEPTH_BYTES));

  // A combined read+write request shares funct3, so either half being illegal
  // kills both.
  assign w_err = (bus.read_en_i || bus.write_en_i) &&
                 ((bus.read_en_i && !w_ld_legal) || (bus.write_en_i && !w_st_legal) ||
                  w_misalign || !w_in_range);

  assign w_load  = bus.read_en_i && !w_err;
  // Gating with rst_n keeps stores from committing while reset is held.
  assign w_store = bus.write_en_i && !w_err && rst_n;

  assign w_idx0 = w_offset[IDX_W-1:0];
  assign w_idx1 = w_idx0 + IDX_W'(1);
  assign w_idx2 = w_idx0 + IDX_W'(2);
  assign w_idx3 = w_idx0 + IDX_W'(3);

  // Reads see pre-store contents, giving read-before-write on combined requests.
  assign w_b0 = r_mem[w_idx0];
  assign w_b1 = r_mem[w_idx1];
  assign w_b2 = r_mem[w_idx2];
  assign w_b3 = r_mem[w_idx3];

  always_comb begin
    w_ld_data = '0;
    case (bus.funct3_i)
      3'b000:  w_ld_data = {{(DWIDTH-8){w_b0[7]}}, w_b0};
      3'b001:  w_ld_data = {{(DWIDTH-16){w_b1[7]}}, w_b1, w_b0};
      3'b010:  w_ld_data = DWIDTH'({w_b3, w_b2, w_b1, w_b0});
      3'b100:  w_ld_data = {{(DWIDTH-8){1'b0}}, w_b0};
      3'b101:  w_ld_data = {{(DWIDTH-16){1'b0}}, w_b1, w_b0};
      default: w_ld_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[w_idx0] <= bus.data_i[7:0];
      if (w_size != 3'd1) begin
        r_mem[w_idx1] <= bus.data_i[15:8];
      end
      if (w_size == 3'd4) begin
        r_mem[w_idx2] <= bus.data_i[23:16];
        r_mem[w_idx3] <= bus.data_i[31:24];
      end
    end
  end

  // Store-only and idle cycles leave r_data holding the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_err) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_err  <= 1'b1;
    end else if (w_load) begin
      r_data <= w_ld_data;
      r_vld  <= 1'b1;
      r_err  <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_err  <= 1'b0;
    end
  end

  assign bus.data_o       = r_data;
  assign bus.data_vld_o   = r_vld;
  assign bus.access_err_o = r_err;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  data_memory_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  data_memory #(
    .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .DEPTH_BYTES(1024)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        v;
    logic        e;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] d;
    logic        v;
    logic        e;
  } req_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_d = 32'h0;
  logic [7:0]  mdl [0:1023];

  function automatic req_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] d, input logic v, input logic e);
    req_t r;
    r.rd = rd; r.wr = wr; r.f3 = f3; r.a = a; r.wd = wd;
    r.d = d; r.v = v; r.e = e;
    return r;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input int off);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{mdl[off][7]}}, mdl[off]};
      3'b001:  r = {{16{mdl[off+1][7]}}, mdl[off+1], mdl[off]};
      3'b010:  r = {mdl[off+3], mdl[off+2], mdl[off+1], mdl[off]};
      3'b100:  r = {24'h0, mdl[off]};
      default: r = {16'h0, mdl[off+1], mdl[off]};
    endcase
    return r;
  endfunction

  task automatic drive(input req_t r);
    @(negedge clk);
    bus.read_en_i  = r.rd;
    bus.write_en_i = r.wr;
    bus.funct3_i   = r.f3;
    bus.addr_i     = r.a;
    bus.data_i     = r.wd;
  endtask

  task automatic push(input logic [31:0] d, input logic v, input logic e);
    exp_t x;
    x.d = d; x.v = v; x.e = e;
    sb.push_back(x);
    if (v || e) last_d = d;
  endtask

  task automatic set_idle();
    bus.read_en_i  = 1'b0;
    bus.write_en_i = 1'b0;
    bus.funct3_i   = 3'b000;
    bus.addr_i     = 32'h0;
    bus.data_i     = 32'h0;
  endtask

  task automatic test_reset();
    set_idle();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_o, bus.data_vld_o, bus.access_err_o} !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_values: got d=%h v=%b e=%b, want 0/0/0",
               bus.data_o, bus.data_vld_o, bus.access_err_o);
    end
    drive(mk(1, 0, 3'b010, BASE, 32'h0, 32'h0, 0, 0));
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.data_o, bus.data_vld_o, bus.access_err_o} !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_ignores_req: got d=%h v=%b e=%b, want 0/0/0",
               bus.data_o, bus.data_vld_o, bus.access_err_o);
    end
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string name, input req_t t[$]);
    exp_t x;
    foreach (t[i]) begin
      drive(t[i]);
      push(t[i].d, t[i].v, t[i].e);
      @(posedge clk); #1;
      x = sb.pop_front();
      n_cmp++;
      if ({bus.data_o, bus.data_vld_o, bus.access_err_o} !== {x.d, x.v, x.e}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got d=%h v=%b e=%b, want d=%h v=%b e=%b", name, i,
                 bus.data_o, bus.data_vld_o, bus.access_err_o, x.d, x.v, x.e);
      end
    end
  endtask

  task automatic test_word_roundtrip();
    req_t t[$];
    t.push_back(mk(0, 1, 3'b010, BASE, 32'hDEADBEEF, 32'h0, 0, 0));
    t.push_back(mk(1, 0, 3'b010, BASE, 32'h0, 32'hDEADBEEF, 1, 0));
    run_table("word_roundtrip", t);
  endtask

  task automatic test_extension();
    req_t t[$];
    t.push_back(mk(1, 0, 3'b000, BASE,     32'h0, 32'hFFFFFFEF, 1, 0));
    t.push_back(mk(1, 0, 3'b100, BASE,     32'h0, 32'h000000EF, 1, 0));
    t.push_back(mk(1, 0, 3'b001, BASE + 2, 32'h0, 32'hFFFFDEAD, 1, 0));
    t.push_back(mk(1, 0, 3'b101, BASE + 2, 32'h0, 32'h0000DEAD, 1, 0));
    t.push_back(mk(0, 0, 3'b000, BASE,     32'h0, 32'h0000DEAD, 0, 0));
    run_table("extension", t);
  endtask

  task automatic test_partial_store();
    req_t t[$];
    t.push_back(mk(0, 1, 3'b010, BASE,     32'hCAFEBABE, 32'h0000DEAD, 0, 0));
    t.push_back(mk(0, 1, 3'b000, BASE + 1, 32'h00000012, 32'h0000DEAD, 0, 0));
    t.push_back(mk(1, 0, 3'b010, BASE,     32'h0,        32'hCAFE12BE, 1, 0));
    run_table("partial_store", t);
  endtask

  task automatic test_errors();
    req_t t[$];
    req_t chk;
    chk = mk(1, 0, 3'b010, BASE, 32'h0, 32'hCAFE12BE, 1, 0);
    t.push_back(mk(1, 0, 3'b010, BASE + 2, 32'h0, 32'h0, 0, 1));
    t.push_back(chk);
    t.push_back(mk(0, 1, 3'b001, BASE + 1, 32'hFFFFFFFF, 32'h0, 0, 1));
    t.push_back(chk);
    t.push_back(mk(1, 0, 3'b011, BASE, 32'h0, 32'h0, 0, 1));
    t.push_back(chk);
    t.push_back(mk(0, 1, 3'b010, 32'h00FFFFFC, 32'h0, 32'h0, 0, 1));
    t.push_back(chk);
    t.push_back(mk(1, 0, 3'b000, BASE + 1024, 32'h0, 32'h0, 0, 1));
    t.push_back(mk(0, 0, 3'b000, BASE, 32'h0, 32'h0, 0, 0));
    t.push_back(chk);
    t.push_back(mk(0, 1, 3'b011, BASE, 32'h0, 32'h0, 0, 1));
    t.push_back(chk);
    run_table("errors", t);
  endtask

  task automatic test_boundary();
    req_t t[$];
    t.push_back(mk(0, 1, 3'b010, BASE + 1020, 32'h55AA33CC, 32'hCAFE12BE, 0, 0));
    t.push_back(mk(1, 0, 3'b010, BASE + 1020, 32'h0, 32'h55AA33CC, 1, 0));
    t.push_back(mk(1, 0, 3'b100, BASE + 1023, 32'h0, 32'h00000055, 1, 0));
    t.push_back(mk(1, 0, 3'b001, BASE + 1022, 32'h0, 32'h000055AA, 1, 0));
    t.push_back(mk(1, 0, 3'b000, BASE + 1022, 32'h0, 32'hFFFFFFAA, 1, 0));
    t.push_back(mk(0, 1, 3'b010, BASE + 1022, 32'h0, 32'h0, 0, 1));
    t.push_back(mk(1, 0, 3'b001, BASE + 1023, 32'h0, 32'h0, 0, 1));
    t.push_back(mk(1, 0, 3'b010, BASE + 1020, 32'h0, 32'h55AA33CC, 1, 0));
    run_table("boundary", t);
  endtask

  task automatic test_simul_rw();
    req_t t[$];
    t.push_back(mk(0, 1, 3'b010, BASE + 4, 32'h11111111, 32'h55AA33CC, 0, 0));
    t.push_back(mk(1, 1, 3'b010, BASE + 4, 32'h22222222, 32'h11111111, 1, 0));
    t.push_back(mk(1, 0, 3'b010, BASE + 4, 32'h0, 32'h22222222, 1, 0));
    t.push_back(mk(1, 1, 3'b100, BASE + 4, 32'h33333333, 32'h0, 0, 1));
    t.push_back(mk(1, 0, 3'b010, BASE + 4, 32'h0, 32'h22222222, 1, 0));
    t.push_back(mk(1, 1, 3'b010, BASE + 6, 32'h44444444, 32'h0, 0, 1));
    t.push_back(mk(1, 0, 3'b010, BASE + 4, 32'h0, 32'h22222222, 1, 0));
    run_table("simul_rw", t);
  endtask

  task automatic test_back_to_back();
    req_t        t[$];
    logic [2:0]  codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] w;
    logic [2:0]  f3;
    int          off;
    for (int k = 0; k < 8; k++) begin
      w = $urandom;
      off = 16 + 4 * k;
      {mdl[off+3], mdl[off+2], mdl[off+1], mdl[off]} = w;
      t.push_back(mk(0, 1, 3'b010, BASE + off, w, 32'h22222222, 0, 0));
    end
    for (int k = 0; k < 20; k++) begin
      f3  = codes[$urandom_range(0, 4)];
      off = 16 + 4 * $urandom_range(0, 7);
      if (f3[1:0] == 2'b00)      off += $urandom_range(0, 3);
      else if (f3[1:0] == 2'b01) off += 2 * $urandom_range(0, 1);
      t.push_back(mk(1, 0, f3, BASE + off, 32'h0, mdl_load(f3, off), 1, 0));
    end
    run_table("back_to_back", t);
  endtask

  task automatic test_reset_mid();
    req_t t[$];
    drive(mk(1, 0, 3'b010, BASE + 4, 32'h0, 32'h0, 0, 0));
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.data_o, bus.data_vld_o, bus.access_err_o} !== {32'h22222222, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL burst_before_reset: got d=%h v=%b e=%b, want 22222222/1/0",
               bus.data_o, bus.data_vld_o, bus.access_err_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_o, bus.data_vld_o, bus.access_err_o} !== 34'h0) begin
      n_bad++;
      $display("FAIL async_reset: got d=%h v=%b e=%b, want 0/0/0",
               bus.data_o, bus.data_vld_o, bus.access_err_o);
    end
    drive(mk(1, 1, 3'b010, BASE, 32'hBADBAD00, 32'h0, 0, 0));
    @(posedge clk);
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.data_o, bus.data_vld_o, bus.access_err_o} !== 34'h0) begin
      n_bad++;
      $display("FAIL held_in_reset: got d=%h v=%b e=%b, want 0/0/0",
               bus.data_o, bus.data_vld_o, bus.access_err_o);
    end
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    t.push_back(mk(1, 0, 3'b010, BASE,     32'h0, 32'hCAFE12BE, 1, 0));
    t.push_back(mk(1, 0, 3'b010, BASE + 4, 32'h0, 32'h22222222, 1, 0));
    t.push_back(mk(0, 0, 3'b000, BASE,     32'h0, 32'h22222222, 0, 0));
    run_table("after_reset", t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_roundtrip();
    test_extension();
    test_partial_store();
    test_errors();
    test_boundary();
    test_simul_rw();
    test_back_to_back();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressable data memory and load/store unit for the memory stage of the pd4 RISC-V datapath. It executes stores and loads from the execute stage and returns the load result, sized and sign/zero-extended, one cycle later. The writeback stage consumes that result as `memory_data_i` when `wbsel` selects wbMEM. The block also flags misaligned, out-of-range and unsupported-size accesses and suppresses them.

## Interface
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width
- `BASE_ADDR`, 32'h01000000, byte address of memory location 0
- `DEPTH_BYTES`, 1024, memory size in bytes; power of two, ≥ 4

Ports:
- `clk` input 1: clock, rising edge
- `rst_n` input 1: reset, asynchronous assert, active-low
- `addr_i` input AWIDTH: byte address (ALU result)
- `data_i` input DWIDTH: store data (rs2)
- `read_en_i` input 1: load request this cycle
- `write_en_i` input 1: store request this cycle
- `funct3_i` input 3: access size and sign
- `data_o` output DWIDTH: extended load result, registered
- `data_vld_o` output 1: `data_o` holds the result of the previous cycle's load
- `access_err_o` output 1: previous cycle's request was suppressed

## Operation
- Storage is `DEPTH_BYTES` bytes, little-endian. Byte offset = `addr_i - BASE_ADDR`, computed modulo 2^AWIDTH.
- Range check: an access is in range only if offset + size ≤ `DEPTH_BYTES`. Addresses below `BASE_ADDR` wrap to large offsets and therefore fail the check.
- Legal `funct3_i` for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal `funct3_i` for stores: 000 SB, 001 SH, 010 SW. Any other value is an error.
- Alignment: halfword accesses need offset[0]=0; word accesses need offset[1:0]=0.
- An erroneous request is suppressed:
  - no memory byte changes;
  - `data_o` is set to 0;
  - `data_vld_o` is 0;
  - `access_err_o` is 1 for one cycle.
- Stores:
  - SB writes `data_i[7:0]` to offset.
  - SH writes `data_i[15:0]` to offset..offset+1.
  - SW writes `data_i` to offset..offset+3.
  - All other bytes are untouched.
- Loads:
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - LW returns the word unchanged.
- Both `read_en_i` and `write_en_i` high:
  - the store commits at the edge;
  - the load returns the pre-store contents (read-before-write).
  - If either half is erroneous, the whole request is suppressed.
- Neither enable high: `data_o` holds its previous value, `data_vld_o`=0, `access_err_o`=0.
- Memory contents are not reset. Contents are 'x until written, and initialisation from a hex file is allowed.

## Timing
- Reset values: `data_o`=0, `data_vld_o`=0, `access_err_o`=0. Outputs go to these values immediately when `rst_n` falls.
- While `rst_n`=0:
  - requests are ignored;
  - no stores commit;
  - memory bytes written before reset keep their values.
- First request accepted: the first rising edge with `rst_n`=1.
- Store: the write occurs at the rising edge that samples `write_en_i`=1. A load one cycle later observes the new data.
- Load latency is one cycle. A request sampled at edge N gives `data_o`/`data_vld_o` valid after edge N, and they stay stable until edge N+1.
- Back-to-back loads are accepted every cycle; throughput is 1 per cycle.
- `access_err_o` and `data_vld_o` are never both 1.
- Wrap-around: the last legal word is at offset `DEPTH_BYTES`-4. A word at offset `DEPTH_BYTES`-2 is misaligned; a byte at offset `DEPTH_BYTES` is out of range.

## Test plan
1. Word round trip:
   - Reset, release, then SW `data_i`=32'hDEADBEEF to 32'h01000000.
   - Next cycle LW from 32'h01000000 → `data_o`=32'hDEADBEEF, `data_vld_o`=1 one cycle after the load.
2. Byte/half extension and endianness (memory at 32'h01000000 = DEADBEEF):
   - LB @+0 → 32'hFFFFFFEF; LBU @+0 → 32'h000000EF.
   - LH @+2 → 32'hFFFFDEAD; LHU @+2 → 32'h0000DEAD.
3. Partial store:
   - SB 32'h00000012 to 32'h01000001 over CAFEBABE.
   - LW then returns 32'hCAFE12BE.
4. Errors, each followed by an LW @+0 that returns unchanged data:
   - LW @32'h01000002, SH @32'h01000001, funct3=011 load, SW @32'h00FFFFFC, LB @BASE_ADDR+DEPTH_BYTES.
   - Each → `access_err_o`=1 for exactly one cycle, `data_o`=0, `data_vld_o`=0.
5. Simultaneous read/write:
   - @+4 holds 32'h11111111; assert LW and SW 32'h22222222 @+4 in the same cycle.
   - → `data_o`=32'h11111111; the next LW returns 32'h22222222.
6. Reset mid-operation:
   - Pull `rst_n` low between clock edges during a load burst → all outputs 0 immediately.
   - A store held during reset does not commit; after release, an LW of an earlier-written word returns its pre-reset value.
